// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and issues word reads over a req/ack port.
// A word acked while the pipeline is stalled is parked in a one-entry buffer (HOLD).
module if_stage #(
    parameter int                ADDR_W       = 30,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 30'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              busy
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] buf_insn, buf_insn_n;
    logic [ADDR_W-1:0] buf_pc, buf_pc_n;
    logic [ADDR_W-1:0] if_pc_n;
    logic [DATA_W-1:0] if_insn_n;
    logic              if_en_n;

    assign mem_req  = (state == FETCH);
    assign mem_addr = pc;
    assign busy     = (state == FETCH) && !mem_ack && !flush && !br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_VECTOR;
            buf_insn <= '0;
            buf_pc   <= '0;
            if_pc    <= '0;
            if_insn  <= '0;
            if_en    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            buf_insn <= buf_insn_n;
            buf_pc   <= buf_pc_n;
            if_pc    <= if_pc_n;
            if_insn  <= if_insn_n;
            if_en    <= if_en_n;
        end
    end

    // Redirects override everything, including stall; an ack in a redirect cycle is dropped.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        buf_insn_n = buf_insn;
        buf_pc_n   = buf_pc;
        if_pc_n    = if_pc;
        if_insn_n  = if_insn;
        if_en_n    = if_en;

        if (flush) begin
            pc_n      = new_pc;
            if_en_n   = 1'b0;
            if_insn_n = '0;
            if_pc_n   = '0;
            state_n   = FETCH;
        end else if (br_taken) begin
            pc_n    = br_addr;
            if_en_n = 1'b0;
            state_n = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (mem_ack) begin
                            if_insn_n = mem_rd_data;
                            if_pc_n   = pc;
                            if_en_n   = 1'b1;
                            pc_n      = pc + ADDR_W'(1);
                        end else begin
                            if_en_n = 1'b0;
                        end
                    end else if (mem_ack) begin
                        buf_insn_n = mem_rd_data;
                        buf_pc_n   = pc;
                        pc_n       = pc + ADDR_W'(1);
                        state_n    = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_insn_n = buf_insn;
                        if_pc_n   = buf_pc;
                        if_en_n   = 1'b1;
                        state_n   = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a scoreboard queue holds the PCs expected to reach decode,
// and a negedge monitor checks every word the decode stage would consume.
module tb_if_stage;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_insn;
    logic              if_en;
    logic              busy;

    int                checks = 0;
    int                errors = 0;
    logic [ADDR_W-1:0] expQ[$];
    logic [ADDR_W-1:0] monExp;

    if_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_VECTOR(30'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rd_data(mem_rd_data), .if_pc(if_pc), .if_insn(if_insn),
        .if_en(if_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory returns a word tagged with the address it was read from.
    assign mem_rd_data = {2'b01, mem_addr};

    function automatic logic [DATA_W-1:0] insnFor(input logic [ADDR_W-1:0] a);
        return {2'b01, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic [ADDR_W-1:0] npc,
                                 input logic br, input logic [ADDR_W-1:0] ba, input logic ack);
        stall    = st;
        flush    = fl;
        new_pc   = npc;
        br_taken = br;
        br_addr  = ba;
        mem_ack  = ack;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #2;
    endtask

    // A presented word is consumed by decode on any cycle it is not stalled or redirected.
    always @(negedge clk) begin
        if (!reset && if_en && !stall && !flush && !br_taken) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid if_pc=%h expected=none", if_pc);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sb_if_pc", 32'(if_pc), 32'(monExp));
                checkOutput("sb_if_insn", if_insn, insnFor(monExp));
            end
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, '0, 0, '0, 0);
        @(posedge clk);
        stepClock();
        checkOutput("rst_if_en", 32'(if_en), 0);
        checkOutput("rst_if_pc", 32'(if_pc), 0);
        checkOutput("rst_if_insn", if_insn, 0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 0);
        checkOutput("rst_mem_req", 32'(mem_req), 1);
        reset = 1'b0;

        // zero-wait memory: one instruction per cycle
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, '0, 0, '0, 1);
            checkOutput("zw_mem_addr", 32'(mem_addr), 32'(i));
            checkOutput("zw_if_en", 32'(if_en), (i > 0) ? 1 : 0);
            checkOutput("zw_busy", 32'(busy), 0);
            expQ.push_back(ADDR_W'(i));
            stepClock();
        end

        // ack every third cycle
        for (int i = 0; i < 6; i++) begin
            logic ack;
            ack = (i % 3 == 2);
            applyStimulus(0, 0, '0, 0, '0, ack);
            checkOutput("sp_mem_addr", 32'(mem_addr), (i < 3) ? 3 : 4);
            checkOutput("sp_busy", 32'(busy), ack ? 0 : 1);
            checkOutput("sp_if_en", 32'(if_en), (i == 0 || i == 3) ? 1 : 0);
            if (ack) expQ.push_back((i < 3) ? 30'd3 : 30'd4);
            stepClock();
        end

        // stall for four cycles, ack on the first one at pc=5
        applyStimulus(1, 0, '0, 0, '0, 1);
        checkOutput("st_mem_addr", 32'(mem_addr), 5);
        checkOutput("st_mem_req", 32'(mem_req), 1);
        expQ.push_back(30'd5);
        stepClock();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, '0, 0, '0, 0);
            checkOutput("hold_mem_req", 32'(mem_req), 0);
            checkOutput("hold_busy", 32'(busy), 0);
            checkOutput("hold_if_pc", 32'(if_pc), 4);
            checkOutput("hold_if_en", 32'(if_en), 1);
            stepClock();
        end
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("rel_mem_addr", 32'(mem_addr), 6);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("rel_if_pc", 32'(if_pc), 5);
        checkOutput("rel_if_en", 32'(if_en), 1);
        checkOutput("rel_next_addr", 32'(mem_addr), 6);
        checkOutput("rel_mem_req", 32'(mem_req), 1);
        stepClock();

        // branch taken with a simultaneous ack: word dropped
        applyStimulus(0, 0, '0, 1, 30'h100, 1);
        checkOutput("br_busy", 32'(busy), 0);
        checkOutput("br_mem_addr", 32'(mem_addr), 6);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 1);
        checkOutput("br_if_en", 32'(if_en), 0);
        checkOutput("br_target", 32'(mem_addr), 32'h100);
        expQ.push_back(30'h100);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("br_next_addr", 32'(mem_addr), 32'h101);
        stepClock();

        // flush while holding a buffered word, with stall and branch also active
        applyStimulus(1, 0, '0, 0, '0, 1);
        checkOutput("fl_mem_addr", 32'(mem_addr), 32'h101);
        stepClock();
        applyStimulus(1, 0, '0, 0, '0, 0);
        checkOutput("fl_hold_req", 32'(mem_req), 0);
        stepClock();
        applyStimulus(1, 1, 30'h40, 1, 30'h80, 0);
        checkOutput("fl_busy", 32'(busy), 0);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 1);
        checkOutput("fl_target", 32'(mem_addr), 32'h40);
        checkOutput("fl_mem_req", 32'(mem_req), 1);
        checkOutput("fl_if_en", 32'(if_en), 0);
        checkOutput("fl_if_pc", 32'(if_pc), 0);
        checkOutput("fl_if_insn", if_insn, 0);
        expQ.push_back(30'h40);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("fl_next_addr", 32'(mem_addr), 32'h41);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("fl_no_leak", 32'(if_en), 0);
        stepClock();

        // PC wraparound
        applyStimulus(0, 1, 30'h3FFFFFFF, 0, '0, 0);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h3FFFFFFF);
        expQ.push_back(30'h3FFFFFFF);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 1);
        checkOutput("wr_wrapped", 32'(mem_addr), 0);
        expQ.push_back(30'h0);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("wr_next", 32'(mem_addr), 1);
        stepClock();

        // reset while holding a buffered word
        applyStimulus(1, 0, '0, 0, '0, 1);
        checkOutput("rh_mem_addr", 32'(mem_addr), 1);
        stepClock();
        reset = 1'b1;
        applyStimulus(1, 0, '0, 0, '0, 0);
        stepClock();
        reset = 1'b0;
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("rh_mem_addr0", 32'(mem_addr), 0);
        checkOutput("rh_mem_req", 32'(mem_req), 1);
        checkOutput("rh_if_en", 32'(if_en), 0);
        checkOutput("rh_if_pc", 32'(if_pc), 0);
        stepClock();
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("rh_buf_lost", 32'(if_en), 0);
        stepClock();

        checkOutput("sb_drained", 32'(expQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
